// File: rtl/irig_symbol_decoder_if.sv
// ---------------------------------------------------------------------------
// irig_symbol_decoder_if
// Bundle between the IRIG-B capture controller (master) and the symbol
// decoder (slave).
//   master -> slave : data_ready, high_count, ref_count
//   slave  -> master: in_frame, bit_valid, bit_class, bit_idx,
//                     frame_done, frame_bits, sync_err
// ---------------------------------------------------------------------------
interface irig_symbol_decoder_if #(
    parameter int CNT_W     = 24,
    parameter int FRAME_LEN = 100
);
    logic                 data_ready;
    logic [CNT_W-1:0]     high_count;
    logic [CNT_W-1:0]     ref_count;
    logic                 in_frame;
    logic                 bit_valid;
    logic [1:0]           bit_class;
    logic [6:0]           bit_idx;
    logic                 frame_done;
    logic [FRAME_LEN-1:0] frame_bits;
    logic                 sync_err;

    modport master (
        output data_ready, high_count, ref_count,
        input  in_frame, bit_valid, bit_class, bit_idx,
               frame_done, frame_bits, sync_err
    );

    modport slave (
        input  data_ready, high_count, ref_count,
        output in_frame, bit_valid, bit_class, bit_idx,
               frame_done, frame_bits, sync_err
    );
endinterface

// File: rtl/irig_symbol_decoder.sv
// ---------------------------------------------------------------------------
// irig_symbol_decoder
// Classifies each measured IRIG-B high-pulse width as ZERO / ONE / MARKER /
// ERROR against the calibrated bit-period count, locks onto frame alignment
// (two consecutive markers), tracks the bit index through the 100-bit frame,
// verifies marker positions and publishes each completed frame.
//
// Ports:
//   clk        system clock
//   hard_rst_n asynchronous active-low reset
//   ce         clock enable; nothing changes while low
//   rst        synchronous soft clear (effective only when ce=1)
//   bus        irig_symbol_decoder_if.slave (strobe/counts in, results out)
// ---------------------------------------------------------------------------
module irig_symbol_decoder #(
    parameter int CNT_W     = 24,
    parameter int FRAME_LEN = 100
) (
    input  logic                  clk,
    input  logic                  hard_rst_n,
    input  logic                  ce,
    input  logic                  rst,
    irig_symbol_decoder_if.slave  bus
);
    localparam int PW = CNT_W + 5;
    localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PREMARK = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'b00,
        CLS_ONE    = 2'b01,
        CLS_MARKER = 2'b10,
        CLS_ERROR  = 2'b11
    } cls_t;

    state_t               state_q, state_d;
    logic [6:0]           idx_q, idx_d;
    logic [FRAME_LEN-1:0] shadow_q, shadow_d;
    logic [FRAME_LEN-1:0] frame_bits_q, frame_bits_d;
    logic                 in_frame_q, in_frame_d;
    logic                 bit_valid_q, bit_valid_d;
    logic [1:0]           bit_class_q, bit_class_d;
    logic [6:0]           bit_idx_q, bit_idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sync_err_q, sync_err_d;

    // ---------------- classification ----------------
    // Thresholds sit at 11/32, 21/32 and 31/32 of the bit period; comparing
    // high*32 against p*k avoids any division.
    logic [PW-1:0] h32, p_ext, p11, p21, p31;
    cls_t          cls;

    always_comb begin
        h32   = {bus.high_count, 5'b0};
        p_ext = {5'b0, bus.ref_count};
        p11   = (p_ext << 3) + (p_ext << 1) + p_ext;
        p21   = (p_ext << 4) + (p_ext << 2) + p_ext;
        p31   = (p_ext << 5) - p_ext;
        if (bus.ref_count == '0) begin
            cls = CLS_ERROR;
        end else if (h32 < p11) begin
            cls = CLS_ZERO;
        end else if (h32 < p21) begin
            cls = CLS_ONE;
        end else if (h32 < p31) begin
            cls = CLS_MARKER;
        end else begin
            cls = CLS_ERROR;
        end
    end

    // ---------------- index tracking ----------------
    logic [6:0] idx_next;
    logic       marker_expected;
    logic       class_ok;

    always_comb begin
        idx_next        = (idx_q == LAST_IDX) ? 7'd0 : idx_q + 7'd1;
        // Position markers sit at 9, 19, ..., 99; the reference marker at 0.
        marker_expected = (idx_next == 7'd0) || ((idx_next % 7'd10) == 7'd9);
        class_ok        = marker_expected ? (cls == CLS_MARKER)
                                          : (cls == CLS_ZERO || cls == CLS_ONE);
    end

    // ---------------- next-state / output logic ----------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        frame_bits_d = frame_bits_q;
        in_frame_d   = in_frame_q;
        bit_valid_d  = bit_valid_q;
        bit_class_d  = bit_class_q;
        bit_idx_d    = bit_idx_q;
        frame_done_d = frame_done_q;
        sync_err_d   = sync_err_q;

        if (ce) begin
            if (rst) begin
                state_d      = ST_SEARCH;
                idx_d        = '0;
                shadow_d     = '0;
                frame_bits_d = '0;
                in_frame_d   = 1'b0;
                bit_valid_d  = 1'b0;
                bit_class_d  = '0;
                bit_idx_d    = '0;
                frame_done_d = 1'b0;
                sync_err_d   = 1'b0;
            end else begin
                bit_valid_d  = 1'b0;
                frame_done_d = 1'b0;
                sync_err_d   = 1'b0;
                if (bus.data_ready) begin
                    bit_valid_d = 1'b1;
                    bit_class_d = cls;
                    unique case (state_q)
                        ST_SEARCH: begin
                            bit_idx_d = '0;
                            if (cls == CLS_MARKER) state_d = ST_PREMARK;
                        end
                        ST_PREMARK: begin
                            bit_idx_d = '0;
                            if (cls == CLS_MARKER) begin
                                // Second marker in a row is the frame reference.
                                state_d    = ST_ALIGNED;
                                idx_d      = '0;
                                shadow_d   = '0;
                                in_frame_d = 1'b1;
                            end else begin
                                state_d = ST_SEARCH;
                            end
                        end
                        ST_ALIGNED: begin
                            bit_idx_d = idx_next;
                            if (class_ok) begin
                                idx_d              = idx_next;
                                shadow_d[idx_next] = (cls == CLS_ONE);
                                if (idx_next == LAST_IDX) begin
                                    frame_done_d = 1'b1;
                                    frame_bits_d = shadow_d;
                                    shadow_d     = '0;
                                end
                            end else begin
                                // A marker in the wrong slot may be the first
                                // of a new marker pair, so keep it.
                                sync_err_d = 1'b1;
                                in_frame_d = 1'b0;
                                shadow_d   = '0;
                                idx_d      = '0;
                                state_d    = (cls == CLS_MARKER) ? ST_PREMARK
                                                                 : ST_SEARCH;
                            end
                        end
                        default: begin
                            state_d = ST_SEARCH;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            state_q      <= ST_SEARCH;
            idx_q        <= '0;
            shadow_q     <= '0;
            frame_bits_q <= '0;
            in_frame_q   <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_class_q  <= '0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frame_bits_q <= frame_bits_d;
            in_frame_q   <= in_frame_d;
            bit_valid_q  <= bit_valid_d;
            bit_class_q  <= bit_class_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.in_frame   = in_frame_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.bit_class  = bit_class_q;
    assign bus.bit_idx    = bit_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_bits = frame_bits_q;
    assign bus.sync_err   = sync_err_q;

endmodule
